line_follow_ctrl: RTL and testbench

- Sits directly downstream of the inductive line-sensor conditioning stage. Consumes its 3-bit conditioned pattern: bit2 = left, bit1 = centre, bit0 = right; 1 = coil over line.
- Debounces the pattern and runs a steering FSM. Counts track junctions.
- Generates left/right motor PWM for the rover drive stage.

---
 rtl/line_pkg.sv | 44 ++++
 rtl/line_follow_ctrl_pwm.sv | 29 ++
 rtl/line_follow_ctrl.sv | 148 ++++++++++++++
 tb/tb_line_follow_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared types and pattern constants for the line-follower rover.
// The upstream sensor conditioning stage uses the same pattern encodings.
package line_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FOLLOW   = 3'd1,
      ST_STEER_L  = 3'd2,
      ST_STEER_R  = 3'd3,
      ST_JUNCTION = 3'd4,
      ST_SEARCH   = 3'd5,
      ST_STOP     = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_CENTRE     = 3'd0,
      CLS_LINE_LEFT  = 3'd1,
      CLS_LINE_RIGHT = 3'd2,
      CLS_JUNC       = 3'd3,
      CLS_NONE       = 3'd4
   } pat_class_t;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_t;

   localparam logic [2:0] PAT_CENTRE = 3'b010;
   localparam logic [2:0] PAT_JUNC   = 3'b111;

   // Bit2 = left coil, bit1 = centre coil, bit0 = right coil.
   function automatic pat_class_t classify(input logic [2:0] pat);
      pat_class_t cls;
      case (pat)
         PAT_CENTRE:       cls = CLS_CENTRE;
         3'b110, 3'b100:   cls = CLS_LINE_LEFT;
         3'b011, 3'b001:   cls = CLS_LINE_RIGHT;
         PAT_JUNC, 3'b101: cls = CLS_JUNC;
         default:          cls = CLS_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/line_follow_ctrl_pwm.sv
// Free-running PWM generator; a new duty is picked up only at the counter wrap
// so a period is never cut short or stretched.
module pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] duty,
   output logic                pwm_out
);

   logic [PWM_BITS-1:0] cnt;
   logic [PWM_BITS-1:0] duty_act;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         duty_act <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         if (cnt == '1)
            duty_act <= duty;
      end
   end

   // Derived from reset registers only, so it drops the moment rst rises.
   assign pwm_out = (cnt < duty_act);

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower steering controller: debounces the coil pattern, runs the
// steering FSM, counts junctions and drives the two wheel PWMs.
module line_follow_ctrl
   import line_pkg::*;
#(
   parameter int DEB_CYCLES   = 4,
   parameter int PWM_BITS     = 8,
   parameter int DUTY_FAST    = 200,
   parameter int DUTY_SLOW    = 80,
   parameter int LOST_TIMEOUT = 1000000,
   parameter int JCNT_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [2:0]        sensor,
   output logic              left_pwm,
   output logic              right_pwm,
   output logic              junction_pulse,
   output logic [JCNT_W-1:0] junction_count,
   output logic              lost,
   output logic [2:0]        state_dbg
);

   localparam int DCW = $clog2(DEB_CYCLES + 1);
   localparam int TW  = (LOST_TIMEOUT > 2) ? $clog2(LOST_TIMEOUT) : 1;
   localparam logic [PWM_BITS-1:0] D_FAST = PWM_BITS'(DUTY_FAST);
   localparam logic [PWM_BITS-1:0] D_SLOW = PWM_BITS'(DUTY_SLOW);

   function automatic logic [PWM_BITS-1:0] duty_of(input state_t s, input dir_t d,
                                                   input logic is_left);
      logic [PWM_BITS-1:0] v;
      case (s)
         ST_FOLLOW, ST_JUNCTION: v = D_FAST;
         ST_STEER_L:             v = is_left ? D_SLOW : D_FAST;
         ST_STEER_R:             v = is_left ? D_FAST : D_SLOW;
         ST_SEARCH:              v = ((d == LEFT) == is_left) ? D_SLOW : D_FAST;
         default:                v = '0;
      endcase
      return v;
   endfunction

   logic [2:0]          sens_p0;
   logic [2:0]          cand;
   logic [2:0]          acc;
   logic [DCW-1:0]      deb_cnt;
   pat_class_t          cls;
   state_t              state;
   state_t              state_nxt;
   dir_t                last_dir;
   dir_t                dir_nxt;
   logic [TW-1:0]       timer;
   logic [PWM_BITS-1:0] duty_l;
   logic [PWM_BITS-1:0] duty_r;

   // Stage p0: input register; then debounce into the accepted pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sens_p0 <= PAT_CENTRE;
         cand    <= PAT_CENTRE;
         acc     <= PAT_CENTRE;
         deb_cnt <= '0;
      end else begin
         sens_p0 <= sensor;
         if (sens_p0 != cand) begin
            cand    <= sens_p0;
            deb_cnt <= DCW'(1);
         end else if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
            acc     <= cand;
            deb_cnt <= DCW'(DEB_CYCLES);
         end else if (deb_cnt < DCW'(DEB_CYCLES)) begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   assign cls = classify(acc);

   always_comb begin
      state_nxt = state;
      dir_nxt   = last_dir;
      if (!enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_FOLLOW;
            ST_STOP: state_nxt = ST_STOP;
            default: begin
               case (cls)
                  CLS_CENTRE:     state_nxt = ST_FOLLOW;
                  CLS_LINE_LEFT:  begin state_nxt = ST_STEER_L; dir_nxt = LEFT;  end
                  CLS_LINE_RIGHT: begin state_nxt = ST_STEER_R; dir_nxt = RIGHT; end
                  CLS_JUNC:       state_nxt = ST_JUNCTION;
                  default: begin
                     // A non-NONE class in the timeout cycle never gets here.
                     if (state == ST_SEARCH && timer == TW'(LOST_TIMEOUT - 1))
                        state_nxt = ST_STOP;
                     else
                        state_nxt = ST_SEARCH;
                  end
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         last_dir       <= LEFT;
         timer          <= '0;
         junction_count <= '0;
         junction_pulse <= 1'b0;
         lost           <= 1'b0;
         duty_l         <= '0;
         duty_r         <= '0;
      end else begin
         state          <= state_nxt;
         last_dir       <= dir_nxt;
         junction_pulse <= (state_nxt == ST_JUNCTION) && (state != ST_JUNCTION);
         if (state == ST_IDLE && state_nxt == ST_FOLLOW)
            junction_count <= '0;
         else if (state_nxt == ST_JUNCTION && state != ST_JUNCTION)
            junction_count <= junction_count + 1'b1;
         timer  <= (state == ST_SEARCH && state_nxt == ST_SEARCH) ? timer + 1'b1 : '0;
         lost   <= (state_nxt == ST_STOP);
         duty_l <= duty_of(state_nxt, dir_nxt, 1'b1);
         duty_r <= duty_of(state_nxt, dir_nxt, 1'b0);
      end
   end

   assign state_dbg = state;

   pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_l (
      .clk     (clk),
      .rst     (rst),
      .duty    (duty_l),
      .pwm_out (left_pwm)
   );

   pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_r (
      .clk     (clk),
      .rst     (rst),
      .duty    (duty_r),
      .pwm_out (right_pwm)
   );

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: expectations are queued as stimulus
// is applied and popped as the matching DUT observation is taken.
module tb_line_follow_ctrl;
   import line_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [2:0] sensor;
   logic       left_pwm;
   logic       right_pwm;
   logic       junction_pulse;
   logic [3:0] junction_count;
   logic       lost;
   logic [2:0] state_dbg;

   line_follow_ctrl #(
      .DEB_CYCLES   (4),
      .PWM_BITS     (8),
      .DUTY_FAST    (200),
      .DUTY_SLOW    (80),
      .LOST_TIMEOUT (50),
      .JCNT_W       (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .sensor         (sensor),
      .left_pwm       (left_pwm),
      .right_pwm      (right_pwm),
      .junction_pulse (junction_pulse),
      .junction_count (junction_count),
      .lost           (lost),
      .state_dbg      (state_dbg)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic observe(input int obs);
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_underflow", 1, 0);
      end else begin
         e = sb.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input int s, input int max, output int n);
      n = 0;
      while (int'(state_dbg) != s && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic measure_pwm(output int lh, output int rh);
      lh = 0;
      rh = 0;
      repeat (256) begin
         @(negedge clk);
         lh += int'(left_pwm);
         rh += int'(right_pwm);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      int lh;
      int rh;
      int bad;
      int pulses;
      int lost_seen;
      int n_search;

      rst    = 1'b1;
      enable = 1'b0;
      sensor = 3'b010;
      tick(3);
      expect_val("rst_state", int'(ST_IDLE));   observe(int'(state_dbg));
      expect_val("rst_left_pwm", 0);            observe(int'(left_pwm));
      expect_val("rst_right_pwm", 0);           observe(int'(right_pwm));
      expect_val("rst_jcnt", 0);                observe(int'(junction_count));
      expect_val("rst_pulse", 0);               observe(int'(junction_pulse));
      expect_val("rst_lost", 0);                observe(int'(lost));

      // Enable with a centred line: FOLLOW, both wheels 200/256.
      rst    = 1'b0;
      enable = 1'b1;
      wait_state(int'(ST_FOLLOW), 20, n);
      expect_val("idle_to_follow_lat", 1);      observe(n);
      tick(300);
      expect_val("follow_left_duty", 200);
      expect_val("follow_right_duty", 200);
      measure_pwm(lh, rh);
      observe(lh);
      observe(rh);

      // Three-sample glitch is rejected.
      sensor = 3'b100;
      tick(3);
      sensor = 3'b010;
      bad = 0;
      repeat (15) begin
         @(negedge clk);
         if (int'(state_dbg) != int'(ST_FOLLOW)) bad++;
      end
      expect_val("glitch_reject", 0);           observe(bad);

      // Held pattern: acc after DEB_CYCLES+1 edges, state one edge later.
      sensor = 3'b100;
      wait_state(int'(ST_STEER_L), 20, n);
      expect_val("steer_l_lat", 6);             observe(n);
      tick(300);
      expect_val("steer_l_left_duty", 80);
      expect_val("steer_l_right_duty", 200);
      measure_pwm(lh, rh);
      observe(lh);
      observe(rh);

      // Two junction entries separated by a centred stretch.
      pulses = 0;
      sensor = 3'b111;
      repeat (20) begin @(negedge clk); pulses += int'(junction_pulse); end
      expect_val("junc1_state", int'(ST_JUNCTION)); observe(int'(state_dbg));
      expect_val("junc1_count", 1);             observe(int'(junction_count));
      sensor = 3'b010;
      repeat (10) begin @(negedge clk); pulses += int'(junction_pulse); end
      expect_val("between_junc_state", int'(ST_FOLLOW)); observe(int'(state_dbg));
      sensor = 3'b111;
      repeat (20) begin @(negedge clk); pulses += int'(junction_pulse); end
      expect_val("junc2_count", 2);             observe(int'(junction_count));
      expect_val("junction_pulses", 2);         observe(pulses);

      // Asynchronous reset while in JUNCTION with the left PWM high.
      n = 0;
      while (!left_pwm && n < 300) begin @(negedge clk); n++; end
      expect_val("pre_rst_left_pwm", 1);        observe(int'(left_pwm));
      expect_val("pre_rst_state", int'(ST_JUNCTION)); observe(int'(state_dbg));
      #2;
      rst = 1'b1;
      #1;
      expect_val("async_rst_left_pwm", 0);      observe(int'(left_pwm));
      expect_val("async_rst_right_pwm", 0);     observe(int'(right_pwm));
      expect_val("async_rst_state", int'(ST_IDLE)); observe(int'(state_dbg));
      expect_val("async_rst_jcnt", 0);          observe(int'(junction_count));
      @(negedge clk);
      sensor = 3'b010;
      rst    = 1'b0;
      wait_state(int'(ST_FOLLOW), 10, n);
      expect_val("post_rst_follow", int'(ST_FOLLOW)); observe(int'(state_dbg));

      // Line lost briefly, recovered well before the timeout.
      lost_seen = 0;
      sensor    = 3'b000;
      repeat (15) begin @(negedge clk); lost_seen |= int'(lost); end
      expect_val("recover_in_search", int'(ST_SEARCH)); observe(int'(state_dbg));
      repeat (15) begin @(negedge clk); lost_seen |= int'(lost); end
      sensor = 3'b010;
      n = 0;
      while (int'(state_dbg) != int'(ST_FOLLOW) && n < 20) begin
         @(negedge clk);
         n++;
         lost_seen |= int'(lost);
      end
      expect_val("recover_follow", int'(ST_FOLLOW)); observe(int'(state_dbg));
      expect_val("recover_no_lost", 0);         observe(lost_seen);

      // Steer right, then lose the line until STOP.
      sensor = 3'b001;
      wait_state(int'(ST_STEER_R), 20, n);
      expect_val("steer_r_state", int'(ST_STEER_R)); observe(int'(state_dbg));
      tick(300);
      expect_val("steer_r_left_duty", 200);
      expect_val("steer_r_right_duty", 80);
      measure_pwm(lh, rh);
      observe(lh);
      observe(rh);
      sensor   = 3'b000;
      n        = 0;
      n_search = 0;
      while (int'(state_dbg) != int'(ST_STOP) && n < 300) begin
         @(negedge clk);
         n++;
         if (int'(state_dbg) == int'(ST_SEARCH)) n_search++;
      end
      expect_val("search_cycles", 50);          observe(n_search);
      expect_val("stop_state", int'(ST_STOP));  observe(int'(state_dbg));
      expect_val("stop_lost", 1);               observe(int'(lost));
      sensor = 3'b010;
      tick(20);
      expect_val("stop_ignores_sensor", int'(ST_STOP)); observe(int'(state_dbg));
      tick(300);
      expect_val("stop_left_duty", 0);
      expect_val("stop_right_duty", 0);
      measure_pwm(lh, rh);
      observe(lh);
      observe(rh);
      enable = 1'b0;
      wait_state(int'(ST_IDLE), 5, n);
      expect_val("disable_to_idle_lat", 1);     observe(n);
      expect_val("idle_lost_clear", 0);         observe(int'(lost));

      check("scoreboard_leftover", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
